// File: rtl/core_fetch_pkg.sv
// rtl/core_fetch_pkg.sv - shared types and helpers for the instruction fetch queue
package core_fetch_pkg;

   // One buffered fetch result: the word address and the instruction read there
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Value presented on o_instr while the queue is empty
   localparam logic [31:0] NOP_INSTR = 32'h0;

   // Clear the byte-offset bits of a fetch address when en is set
   function automatic logic [31:0] align_pc(input logic [31:0] addr, input logic en);
      return en ? {addr[31:2], 2'b00} : addr;
   endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// rtl/core_fetch_fifo.sv - ring buffer of fetch entries with single-cycle flush
module core_fetch_fifo
   import core_fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     push_entry,
   output logic [PTR_W:0]   count,
   output fetch_entry_t     head
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             pop_ok;

   // Next pointers, occupancy and storage; flush overrides push and pop
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_ok   = pop & (count_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count = count_q;
   assign head  = (count_q == '0) ? fetch_entry_t'{pc: 32'h0, instr: NOP_INSTR}
                                  : mem_q[rd_ptr_q];

endmodule

// File: rtl/core_fetch_queue.sv
// rtl/core_fetch_queue.sv - prefetching IF stage; CORE_FETCH_PERF_EN adds perf counters
module core_fetch_queue
   import core_fetch_pkg::*;
#(
   parameter  int DEPTH      = 4,
   parameter  int BOOT_ALIGN = 1,
   localparam int PTR_W      = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_boot_addr,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        bus_rd_req,
   output logic [31:0] bus_rd_addr,
   input  logic        bus_rd_gnt,
   input  logic [31:0] bus_rd_data,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   input  logic        i_ready
`ifdef CORE_FETCH_PERF_EN
   ,
   output logic [31:0] o_perf_starve_cnt,
   output logic [31:0] o_perf_flush_cnt
`endif
);

   localparam logic             ALIGN_EN = (BOOT_ALIGN != 0);
   localparam logic [PTR_W+1:0] DEPTH_W  = (PTR_W+2)'(DEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      inflight_pc_q, inflight_pc_d;
   logic             inflight_q, inflight_d;
   logic [PTR_W:0]   fifo_count;
   logic [PTR_W+1:0] occupancy;
   logic             credit_ok;
   logic             issue;
   logic             fifo_push;
   logic             fifo_pop;
   fetch_entry_t     rsp_entry;
   fetch_entry_t     fifo_head;

   // Credit check, bus request and queue push/pop decisions for this cycle
   always_comb begin
      occupancy  = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, inflight_q};
      credit_ok  = (occupancy < DEPTH_W);
      bus_rd_req = rst_n & ~i_redirect & credit_ok;
      issue      = bus_rd_req & bus_rd_gnt;
      fifo_push  = inflight_q & ~i_redirect;
      fifo_pop   = o_valid & i_ready & ~i_redirect;
      rsp_entry  = '{pc: inflight_pc_q, instr: bus_rd_data};
   end

   // Fetch address and in-flight tracking; a redirect restarts from the new pc
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      if (i_redirect) begin
         fetch_pc_d = align_pc(i_redirect_pc, ALIGN_EN);
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         inflight_pc_d = fetch_pc_q;
      end
   end

   // Fetch state registers; reset loads the boot address and drops any in-flight read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= align_pc(i_boot_addr, ALIGN_EN);
         inflight_pc_q <= 32'h0;
         inflight_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   core_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (fifo_push),
      .pop        (fifo_pop),
      .flush      (i_redirect),
      .push_entry (rsp_entry),
      .count      (fifo_count),
      .head       (fifo_head)
   );

   assign bus_rd_addr = fetch_pc_q;
   assign o_valid     = (fifo_count != '0);
   assign o_pc        = fifo_head.pc;
   assign o_instr     = fifo_head.instr;

`ifdef CORE_FETCH_PERF_EN
   logic [31:0] starve_cnt_q, starve_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating counts of starved ID cycles and of redirects that discard work
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (i_ready & ~o_valid & ~i_redirect & (starve_cnt_q != 32'hFFFF_FFFF)) begin
         starve_cnt_d = starve_cnt_q + 32'd1;
      end
      if (i_redirect & (o_valid | inflight_q) & (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Perf counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= 32'h0;
         flush_cnt_q  <= 32'h0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign o_perf_starve_cnt = starve_cnt_q;
   assign o_perf_flush_cnt  = flush_cnt_q;
`else
   // No perf counters in this configuration
`endif

endmodule

// File: tb/tb_core_fetch_queue.sv
// tb/tb_core_fetch_queue.sv - self-checking bench for core_fetch_queue (CORE_FETCH_PERF_EN optional)
module tb_core_fetch_queue;

   localparam int          DEPTH      = 4;
   localparam int          BOOT_ALIGN = 1;
   localparam logic [31:0] KEY        = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_boot_addr = 32'h0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic        bus_rd_req;
   logic [31:0] bus_rd_addr;
   logic        bus_rd_gnt = 1'b0;
   logic [31:0] bus_rd_data = 32'h0;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        i_ready = 1'b0;
`ifdef CORE_FETCH_PERF_EN
   logic [31:0] o_perf_starve_cnt;
   logic [31:0] o_perf_flush_cnt;
`endif

   core_fetch_queue #(
      .DEPTH      (DEPTH),
      .BOOT_ALIGN (BOOT_ALIGN)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_boot_addr   (i_boot_addr),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .bus_rd_req    (bus_rd_req),
      .bus_rd_addr   (bus_rd_addr),
      .bus_rd_gnt    (bus_rd_gnt),
      .bus_rd_data   (bus_rd_data),
      .o_valid       (o_valid),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .i_ready       (i_ready)
`ifdef CORE_FETCH_PERF_EN
      ,
      .o_perf_starve_cnt (o_perf_starve_cnt),
      .o_perf_flush_cnt  (o_perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of {pc, instr}, one outstanding read, next fetch pc
   logic [63:0] m_q [$];
   logic        m_inflight;
   logic [31:0] m_inflight_pc;
   logic [31:0] m_fetch_pc;
   logic [31:0] deliv [$];
   logic [31:0] last_pc;
   bit          have_last;
   int          grants;

   typedef struct {
      logic        gnt;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_align(input logic [31:0] a);
      return (BOOT_ALIGN != 0) ? (a & 32'hFFFF_FFFC) : a;
   endfunction

   task automatic model_init(input logic [31:0] boot);
      m_q.delete();
      m_inflight    = 1'b0;
      m_inflight_pc = 32'h0;
      m_fetch_pc    = m_align(boot);
      deliv.delete();
      have_last     = 1'b0;
      grants        = 0;
   endtask

   // Compare DUT against the model at the falling edge, then advance the model
   task automatic cycle_check();
      logic        exp_req;
      logic        pop;
      logic [31:0] hpc;
      logic [31:0] hins;
      bus_rd_data = m_inflight ? (m_inflight_pc ^ KEY) : $urandom();
      @(negedge clk);
      exp_req = !i_redirect && ((m_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
      hpc     = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
      hins    = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
      chk("bus_rd_req", {31'b0, bus_rd_req}, {31'b0, exp_req});
      if (exp_req) chk("bus_rd_addr", bus_rd_addr, m_fetch_pc);
      chk("o_valid", {31'b0, o_valid}, {31'b0, (m_q.size() != 0)});
      chk("o_pc", o_pc, hpc);
      chk("o_instr", o_instr, hins);
      if (o_valid) chk("instr_matches_pc", o_instr, o_pc ^ KEY);
      chk("no_push_when_full", {31'b0, (dut.fifo_push && (dut.fifo_count == DEPTH))}, 32'h0);
      if (bus_rd_req && bus_rd_gnt) grants++;
      pop = (m_q.size() != 0) && i_ready && !i_redirect;
      if (pop) begin
         if (have_last) chk("pc_step", o_pc, last_pc + 32'd4);
         last_pc   = o_pc;
         have_last = 1'b1;
         deliv.push_back(o_pc);
      end
      if (i_redirect) begin
         have_last = 1'b0;
         m_q.delete();
         m_inflight = 1'b0;
         m_fetch_pc = m_align(i_redirect_pc);
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_inflight) m_q.push_back({m_inflight_pc, m_inflight_pc ^ KEY});
         if (exp_req && bus_rd_gnt) begin
            m_inflight    = 1'b1;
            m_inflight_pc = m_fetch_pc;
            m_fetch_pc    = m_fetch_pc + 32'd4;
         end else begin
            m_inflight = 1'b0;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      cycle_check();
      advance();
   endtask

   task automatic do_reset(input logic [31:0] boot);
      rst_n         = 1'b0;
      i_boot_addr   = boot;
      bus_rd_gnt    = 1'b0;
      i_ready       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_o_valid", {31'b0, o_valid}, 32'h0);
      chk("rst_o_pc", o_pc, 32'h0);
      chk("rst_o_instr", o_instr, 32'h0);
      chk("rst_bus_rd_req", {31'b0, bus_rd_req}, 32'h0);
      advance();
      rst_n = 1'b1;
      model_init(boot);
   endtask

   initial begin
      // gnt, rdy, redir, rpc, exp_req, exp_addr, exp_valid, exp_pc
      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b1, 32'h00C};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200};

      // Boot from an unaligned address, then redirect while a read is in flight
      do_reset(32'h0000_0002);
      for (int i = 0; i < 9; i++) begin
         bus_rd_gnt    = vecs[i].gnt;
         i_ready       = vecs[i].rdy;
         i_redirect    = vecs[i].redir;
         i_redirect_pc = vecs[i].rpc;
         cycle_check();
         chk($sformatf("vec%0d_req", i), {31'b0, bus_rd_req}, {31'b0, vecs[i].exp_req});
         if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), bus_rd_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
         advance();
      end
      i_redirect = 1'b0;

      // Backpressure: queue fills to DEPTH, then drains in order
      do_reset(32'h0000_0100);
      bus_rd_gnt = 1'b1;
      i_ready    = 1'b0;
      repeat (8) step();
      chk("bp_grants", grants, DEPTH);
      chk("bp_req_low", {31'b0, bus_rd_req}, 32'h0);
      chk("bp_head_pc", o_pc, 32'h100);
      i_ready = 1'b1;
      repeat (12) step();
      if (deliv.size() < 8) chk("bp_delivered_count", deliv.size(), 8);
      else for (int i = 0; i < 8; i++) chk($sformatf("bp_pc%0d", i), deliv[i], 32'h100 + 32'(4 * i));

      // Address wrap at the top of memory
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFF_FFF8;
      step();
      i_redirect = 1'b0;
      deliv.delete();
      repeat (6) step();
      if (deliv.size() < 3) chk("wrap_delivered_count", deliv.size(), 3);
      else begin
         chk("wrap_pc0", deliv[0], 32'hFFFF_FFF8);
         chk("wrap_pc1", deliv[1], 32'hFFFF_FFFC);
         chk("wrap_pc2", deliv[2], 32'h0000_0000);
      end

      // Random grant / ready / redirect traffic against the model
      do_reset($urandom());
      for (int c = 0; c < 10000; c++) begin
         bus_rd_gnt    = ($urandom_range(0, 1) == 1);
         i_ready       = ($urandom_range(0, 9) < 7);
         i_redirect    = ($urandom_range(0, 99) < 3);
         i_redirect_pc = $urandom();
         step();
      end
      i_redirect = 1'b0;

`ifdef CORE_FETCH_PERF_EN
      // Starve and flush counters
      do_reset(32'h0);
      i_ready    = 1'b1;
      bus_rd_gnt = 1'b0;
      repeat (5) step();
      i_ready       = 1'b0;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h80;
      step();
      i_redirect = 1'b0;
      bus_rd_gnt = 1'b1;
      repeat (3) step();
      i_redirect = 1'b1;
      step();
      i_redirect = 1'b0;
      bus_rd_gnt = 1'b0;
      step();
      chk("perf_starve", o_perf_starve_cnt, 32'd5);
      chk("perf_flush", o_perf_flush_cnt, 32'd1);
`endif

      // Asynchronous reset mid-stream clears outputs immediately
      do_reset(32'h40);
      bus_rd_gnt = 1'b1;
      i_ready    = 1'b1;
      i_redirect = 1'b1;
      step();
      i_redirect = 1'b0;
      repeat (6) step();
      chk("pre_rst_valid", {31'b0, o_valid}, 32'h1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'b0, o_valid}, 32'h0);
      chk("async_rst_pc", o_pc, 32'h0);
      chk("async_rst_req", {31'b0, bus_rd_req}, 32'h0);
`ifdef CORE_FETCH_PERF_EN
      chk("async_rst_starve", o_perf_starve_cnt, 32'h0);
      chk("async_rst_flush", o_perf_flush_cnt, 32'h0);
`endif
      bus_rd_gnt = 1'b0;
      i_ready    = 1'b0;
      advance();
      rst_n = 1'b1;
      model_init(32'h40);
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
